// File: rtl/ps2_rx_if.sv
// PS/2 receiver port bundle: raw line inputs, enable,
// and the received byte with its status strobes.
interface ps2_rx_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2c, ps2d, rx_en,
    input  scan_code, scan_code_ready,
    input  parity_err, frame_err
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output scan_code, scan_code_ready,
    output parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and
// de-glitches ps2c, shifts in 11-bit frames, flags errors.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic     clk,
  input  logic     reset,
  ps2_rx_if.slave  bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_e;

  logic                  c_meta_q, c_sync_q;
  logic                  d_meta_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q;
  logic                  filt_q, filt_d;
  logic                  filt_prev_q;
  logic                  fall;
  logic                  wd_hit;

  state_e                state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic                  par_q;
  logic [WDW-1:0]        wd_q;
  logic [7:0]            code_q;
  logic                  rdy_q, perr_q, ferr_q;

  always_comb begin
    filt_d = filt_q;
    if (&filt_sr_q)
      filt_d = 1'b1;
    else if (~|filt_sr_q)
      filt_d = 1'b0;
  end

  assign fall   = filt_prev_q & ~filt_q;
  assign wd_hit = (state_q != IDLE) &&
                  (wd_q >= WDW'(TIMEOUT - 1));

  // Line idle level is high, so everything resets to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_meta_q    <= 1'b1;
      c_sync_q    <= 1'b1;
      d_meta_q    <= 1'b1;
      d_sync_q    <= 1'b1;
      filt_sr_q   <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      c_meta_q    <= bus.ps2c;
      c_sync_q    <= c_meta_q;
      d_meta_q    <= bus.ps2d;
      d_sync_q    <= d_meta_q;
      filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0],
                      c_sync_q};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wd_q      <= '0;
      code_q    <= '0;
      rdy_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (!bus.rx_en) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        wd_q      <= '0;
      end else if (wd_hit) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        wd_q      <= '0;
        ferr_q    <= 1'b1;
      end else begin
        if (fall || state_q == IDLE)
          wd_q <= '0;
        else if (wd_q != '1)
          wd_q <= wd_q + 1'b1;
        if (fall) begin
          unique case (state_q)
            IDLE: begin
              if (!d_sync_q) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end
            end
            DATA: begin
              shift_q   <= {d_sync_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7)
                state_q <= PARITY;
            end
            PARITY: begin
              par_q   <= d_sync_q;
              state_q <= STOP;
            end
            STOP: begin
              state_q <= IDLE;
              if (!d_sync_q)
                ferr_q <= 1'b1;
              else if (^{shift_q, par_q}) begin
                code_q <= shift_q;
                rdy_q  <= 1'b1;
              end else
                perr_q <= 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.scan_code       = code_q;
  assign bus.scan_code_ready = rdy_q;
  assign bus.parity_err      = perr_q;
  assign bus.frame_err       = ferr_q;

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, 8, number of consecutive equal ps2c samples needed to change the filtered clock.
REQ-002 Parameter TIMEOUT, 20000, clk cycles without a filtered ps2c falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2d  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 ps2c  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 rx_en  input  1  receive enable; low forces the receiver idle.
REQ-008 scan_code  output  8  last correctly received data byte.
REQ-009 scan_code_ready  output  1  one-cycle strobe marking a new scan_code.
REQ-010 parity_err  output  1  one-cycle strobe: frame had a good stop bit but bad odd parity.
REQ-011 frame_err  output  1  one-cycle strobe: stop bit was 0, or the frame timed out.

Function
REQ-012 The block shall pass ps2c and ps2d through a 2-flop synchronizer each before any other use.
REQ-013 The filtered clock shall go to 1 when the last FILTER_LEN synced ps2c samples are all 1, go to 0 when they are all 0, and otherwise hold its value.
REQ-014 A fall strobe (1 cycle) shall be generated when the filtered clock was 1 on the previous cycle and is 0 now.
REQ-015 The data bit for each fall shall be the synced ps2d value in the same cycle as the fall strobe.
REQ-016 FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: fall with data 0 -> DATA with bit_cnt=0.
- IDLE: fall with data 1 -> ignored, no error.
REQ-017 DATA shall shift bits in LSB-first and increment a 3-bit bit_cnt on each fall, moving to PARITY after the 8th bit.
REQ-018 PARITY shall store the bit on the next fall and move to STOP.
REQ-019 STOP, on fall, shall always return to IDLE and produce exactly one of the following results:
- stop=1 and the ones-count of 8 data bits + parity is odd -> load scan_code and assert scan_code_ready.
- stop=1 and that count is even -> assert parity_err; scan_code unchanged.
- stop=0 -> assert frame_err; scan_code unchanged.
REQ-020 All strobes shall be asserted exactly one clk cycle after the fall strobe that sampled the stop bit, and shall be high for exactly one cycle.
REQ-021 scan_code shall change only in the cycle where scan_code_ready is high, and shall otherwise hold.
REQ-022 A watchdog counter shall clear on every fall strobe and in IDLE.
- Outside IDLE, on reaching TIMEOUT-1 the FSM shall go to IDLE and assert frame_err for one cycle.
- The watchdog counter shall saturate.
REQ-023 With rx_en low the FSM shall be held in IDLE and the bit counter cleared, with no strobes; a frame in progress is dropped silently and scan_code is held.
REQ-024 If a fall coincides with the timeout, the timeout shall take priority; rx_en low shall take priority over both.
REQ-025 Back-to-back frames shall be accepted without dead cycles; the start bit of the next frame may arrive on the first fall after STOP.

Reset
REQ-026 While reset is low, all of the following shall hold:
- scan_code = 8'h00; scan_code_ready, parity_err and frame_err = 0.
- FSM = IDLE; bit_cnt and watchdog = 0.
- Synchronizer and filter flops = 1, and the filtered clock = 1.
REQ-027 Deasserting reset mid-frame shall leave the FSM in IDLE; the remaining bits of that frame shall be ignored until a valid start bit is seen.

Verification
REQ-028 Frame 0x1C (start 0; bits 0,0,1,1,1,0,0,0; parity 0; stop 1), ps2c period 60 us -> scan_code=8'h1C with one scan_code_ready pulse; no error strobes.
REQ-029 Frame 0x1C with parity 1 -> one parity_err pulse, no scan_code_ready, scan_code unchanged.
REQ-030 Frame 0xF0 (parity 1) with stop 0 -> one frame_err pulse, no ready, scan_code unchanged.
REQ-031 Start + 3 data bits, then ps2c held high for TIMEOUT+10 cycles -> one frame_err pulse and FSM in IDLE; a following 0xF0 frame -> scan_code=8'hF0 with ready.
REQ-032 ps2c low glitch of 3 clk cycles while in IDLE -> no fall strobe, no state change; a clean 0x1C frame afterwards is received correctly.
REQ-033 Back-to-back 0xF0 then 0x1C -> two ready pulses carrying 8'hF0 then 8'h1C; reset pulled low mid-second-frame -> all outputs 0 and the remainder is ignored.
